// File: rtl/stream_packet_fifo.sv
// Avalon-ST packet FIFO sitting behind the endian swapper: cut-through or
// store-and-forward egress, plus an Avalon-MM port for mode, status and watermark.
module stream_packet_fifo #(
  parameter int DATA_BYTES = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BYTES*8-1:0]       stream_in_data,
  input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
  input  logic                          stream_in_valid,
  input  logic                          stream_in_startofpacket,
  input  logic                          stream_in_endofpacket,
  output logic                          stream_in_ready,
  output logic [DATA_BYTES*8-1:0]       stream_out_data,
  output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
  output logic                          stream_out_valid,
  output logic                          stream_out_startofpacket,
  output logic                          stream_out_endofpacket,
  input  logic                          stream_out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);

  localparam int DW = DATA_BYTES * 8;
  localparam int EW = $clog2(DATA_BYTES);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int WW = DW + EW + 2;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] r_pkt_count;
  logic [LW-1:0] r_hwm;
  logic          r_sf;
  logic          r_oversize;
  logic          r_release;
  logic [31:0]   r_csr_rdata;
  logic          r_csr_rvalid;

  logic [WW-1:0] w_in_entry;
  logic [WW-1:0] w_out_entry;
  logic          w_push;
  logic          w_pop;
  logic          w_in_eop;
  logic          w_out_eop;
  logic          w_full;
  logic          w_release_set;
  logic          w_csr_wr;
  logic [LW-1:0] w_level_nxt;
  logic [LW-1:0] w_pkt_nxt;
  logic [31:0]   w_csr_rdata;
  logic          w_unused_wdata;

  assign w_in_entry  = {stream_in_data, stream_in_empty,
                        stream_in_startofpacket, stream_in_endofpacket};
  assign w_out_entry = r_mem[r_rd_ptr];

  assign stream_out_data          = w_out_entry[WW-1:EW+2];
  assign stream_out_empty         = w_out_entry[EW+1:2];
  assign stream_out_startofpacket = w_out_entry[1];
  assign w_out_eop                = w_out_entry[0];
  assign stream_out_endofpacket   = w_out_eop;
  assign w_in_eop                 = stream_in_endofpacket;

  assign w_full          = (r_level == FULL_LVL);
  assign stream_in_ready = reset_n & ~w_full;
  // In store-and-forward, hold egress until a whole packet is buffered or
  // the packet has been declared oversize and must stream through.
  assign stream_out_valid = (r_level != '0) &
                            (~r_sf | (r_pkt_count != '0) | r_release);

  assign w_push        = stream_in_valid & stream_in_ready;
  assign w_pop         = stream_out_valid & stream_out_ready;
  assign w_release_set = r_sf & w_full & (r_pkt_count == '0);
  assign w_csr_wr      = csr_write & ~csr_read;

  assign csr_waitrequest   = ~reset_n;
  assign csr_readdata      = r_csr_rdata;
  assign csr_readdatavalid = r_csr_rvalid;
  assign w_unused_wdata    = ^csr_writedata[31:2];

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_comb begin
    w_pkt_nxt = r_pkt_count;
    case ({w_push & w_in_eop, w_pop & w_out_eop})
      2'b10:   w_pkt_nxt = r_pkt_count + LW'(1);
      2'b01:   w_pkt_nxt = r_pkt_count - LW'(1);
      default: w_pkt_nxt = r_pkt_count;
    endcase
  end

  always_comb begin
    w_csr_rdata = '0;
    case (csr_address)
      2'd0:    w_csr_rdata = {30'd0, r_oversize, r_sf};
      2'd1:    w_csr_rdata = 32'(r_level);
      2'd2:    w_csr_rdata = 32'(r_pkt_count);
      2'd3:    w_csr_rdata = 32'(r_hwm);
      default: w_csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level     <= w_level_nxt;
      r_pkt_count <= w_pkt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_release <= 1'b0;
    end else if (w_release_set) begin
      r_release <= 1'b1;
    end else if (w_pop && w_out_eop) begin
      r_release <= 1'b0;
    end
  end

  // A new oversize event outranks a simultaneous write-one-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sf       <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      if (w_csr_wr && csr_address == 2'd0) begin
        r_sf <= csr_writedata[0];
      end
      if (w_release_set) begin
        r_oversize <= 1'b1;
      end else if (w_csr_wr && csr_address == 2'd0 && csr_writedata[1]) begin
        r_oversize <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hwm <= '0;
    end else if (w_csr_wr && csr_address == 2'd3) begin
      r_hwm <= r_level;
    end else if (w_level_nxt > r_hwm) begin
      r_hwm <= w_level_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csr_rvalid <= 1'b0;
      r_csr_rdata  <= '0;
    end else begin
      r_csr_rvalid <= csr_read;
      if (csr_read) begin
        r_csr_rdata <= w_csr_rdata;
      end
    end
  end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Bench for stream_packet_fifo: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based model of the FIFO.
module tb_stream_packet_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 64;
  localparam int EW    = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] stream_in_data;
  logic [EW-1:0] stream_in_empty;
  logic          stream_in_valid;
  logic          stream_in_startofpacket;
  logic          stream_in_endofpacket;
  logic          stream_in_ready;
  logic [DW-1:0] stream_out_data;
  logic [EW-1:0] stream_out_empty;
  logic          stream_out_valid;
  logic          stream_out_startofpacket;
  logic          stream_out_endofpacket;
  logic          stream_out_ready;
  logic [1:0]    csr_address;
  logic          csr_read;
  logic          csr_write;
  logic [31:0]   csr_writedata;
  logic [31:0]   csr_readdata;
  logic          csr_readdatavalid;
  logic          csr_waitrequest;

  stream_packet_fifo #(.DATA_BYTES(8), .DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .stream_in_data           (stream_in_data),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_ready          (stream_in_ready),
    .stream_out_data          (stream_out_data),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_ready         (stream_out_ready),
    .csr_address              (csr_address),
    .csr_read                 (csr_read),
    .csr_write                (csr_write),
    .csr_writedata            (csr_writedata),
    .csr_readdata             (csr_readdata),
    .csr_readdatavalid        (csr_readdatavalid),
    .csr_waitrequest          (csr_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic          s;
    logic          eo;
    logic          ordy;
    logic          x_rdy;
    logic          x_vld;
    logic [DW-1:0] x_d;
    logic [EW-1:0] x_e;
    logic          x_s;
    logic          x_eo;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents as a queue plus the mode/flag state.
  beat_t q[$];
  bit    m_sf, m_rel, m_ovs;
  int    m_hwm;
  bit    last_push;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pkt_cnt();
    int n = 0;
    foreach (q[i]) if (q[i].eop) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_sf = 0; m_rel = 0; m_ovs = 0; m_hwm = 0; last_push = 0;
  endtask

  // One clock: called at a negedge with inputs set, returns at the next negedge.
  task automatic cycle();
    int pc, lvl_pre;
    bit exp_rdy, exp_vld, push, pop, rset, rd_now, wr;
    logic [1:0] a;
    logic [31:0] wd, rd_exp;
    beat_t b;
    #1;
    pc      = pkt_cnt();
    lvl_pre = q.size();
    exp_rdy = (lvl_pre != DEPTH);
    exp_vld = (lvl_pre != 0) && (!m_sf || pc != 0 || m_rel);
    chk("in_ready", stream_in_ready, exp_rdy);
    chk("out_valid", stream_out_valid, exp_vld);
    if (exp_vld && stream_out_valid) begin
      chk("out_data", stream_out_data, q[0].data);
      chk("out_empty", stream_out_empty, q[0].empty);
      chk("out_sop", stream_out_startofpacket, q[0].sop);
      chk("out_eop", stream_out_endofpacket, q[0].eop);
    end
    push   = stream_in_valid && exp_rdy;
    pop    = exp_vld && stream_out_ready;
    rset   = m_sf && lvl_pre == DEPTH && pc == 0;
    rd_now = csr_read;
    wr     = csr_write && !csr_read;
    a      = csr_address;
    wd     = csr_writedata;
    case (a)
      2'd0:    rd_exp = {30'd0, m_ovs, m_sf};
      2'd1:    rd_exp = 32'(lvl_pre);
      2'd2:    rd_exp = 32'(pc);
      default: rd_exp = 32'(m_hwm);
    endcase
    b.data  = stream_in_data;
    b.empty = stream_in_empty;
    b.sop   = stream_in_startofpacket;
    b.eop   = stream_in_endofpacket;
    @(posedge clk);
    if (pop) begin
      beat_t o;
      o = q.pop_front();
      if (o.eop) m_rel = 0;
    end
    if (push) q.push_back(b);
    if (rset) m_rel = 1;
    if (rset) m_ovs = 1;
    else if (wr && a == 2'd0 && wd[1]) m_ovs = 0;
    if (wr && a == 2'd0) m_sf = wd[0];
    if (wr && a == 2'd3) m_hwm = lvl_pre;
    else if (q.size() > m_hwm) m_hwm = q.size();
    last_push = push;
    @(negedge clk);
    chk("rd_valid", csr_readdatavalid, rd_now);
    if (rd_now) chk("rd_data", csr_readdata, rd_exp);
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [EW-1:0] e,
                            input logic s, input logic eo);
    stream_in_valid = 1; stream_in_data = d; stream_in_empty = e;
    stream_in_startofpacket = s; stream_in_endofpacket = eo;
  endtask

  task automatic idle_in();
    stream_in_valid = 0; stream_in_data = '0; stream_in_empty = '0;
    stream_in_startofpacket = 0; stream_in_endofpacket = 0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    csr_read = 1; csr_address = a;
    cycle();
    csr_read = 0;
    chk(nm, csr_readdata, exp);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_write = 1; csr_address = a; csr_writedata = d;
    cycle();
    csr_write = 0;
  endtask

  task automatic drain(input string nm);
    idle_in();
    stream_out_ready = 1;
    for (int i = 0; i < 60 && q.size() != 0; i++) cycle();
    chk(nm, q.size(), 0);
  endtask

  vec_t tbl[5];

  initial begin
    int n, pos, len, bias, r;
    tbl[0] = '{1, 64'h1111111111111111, 0, 1, 0, 1, 1, 0, 64'h0, 0, 0, 0};
    tbl[1] = '{1, 64'h2222222222222222, 0, 0, 0, 1, 1, 1, 64'h1111111111111111, 0, 1, 0};
    tbl[2] = '{1, 64'h3333333333333333, 3, 0, 1, 1, 1, 1, 64'h2222222222222222, 0, 0, 0};
    tbl[3] = '{0, 64'h0, 0, 0, 0, 1, 1, 1, 64'h3333333333333333, 3, 0, 1};
    tbl[4] = '{0, 64'h0, 0, 0, 0, 1, 1, 0, 64'h0, 0, 0, 0};

    reset_n = 0; idle_in(); stream_out_ready = 0;
    csr_read = 0; csr_write = 0; csr_address = 0; csr_writedata = 0;
    model_reset();
    #12;
    chk("rst_out_valid", stream_out_valid, 0);
    chk("rst_in_ready", stream_in_ready, 0);
    chk("rst_waitreq", csr_waitrequest, 1);
    chk("rst_rdvalid", csr_readdatavalid, 0);
    chk("rst_rdata", csr_readdata, 0);
    @(negedge clk);
    reset_n = 1;
    #1 chk("waitreq_run", csr_waitrequest, 0);

    // cut-through 3-beat packet
    for (int i = 0; i < 5; i++) begin
      stream_in_valid = tbl[i].iv; stream_in_data = tbl[i].d; stream_in_empty = tbl[i].e;
      stream_in_startofpacket = tbl[i].s; stream_in_endofpacket = tbl[i].eo;
      stream_out_ready = tbl[i].ordy;
      #1;
      chk("tbl_rdy", stream_in_ready, tbl[i].x_rdy);
      chk("tbl_vld", stream_out_valid, tbl[i].x_vld);
      if (tbl[i].x_vld) begin
        chk("tbl_data", stream_out_data, tbl[i].x_d);
        chk("tbl_empty", stream_out_empty, tbl[i].x_e);
        chk("tbl_sop", stream_out_startofpacket, tbl[i].x_s);
        chk("tbl_eop", stream_out_endofpacket, tbl[i].x_eo);
      end
      cycle();
    end
    csr_rd(2'd3, 1, "hwm_after_3beat");

    // fill to DEPTH with egress stalled, then push and pop concurrently
    stream_out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_beat(64'hA0 + i, 0, i == 0, 0);
      cycle();
    end
    n = DEPTH;
    drive_beat(64'hA0 + n, 0, 0, 0);
    #1 chk("full_in_ready", stream_in_ready, 0);
    csr_rd(2'd1, 16, "level_full");
    stream_out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (last_push) n++;
      drive_beat(64'hA0 + n, 0, 0, n == 40);
    end
    csr_rd(2'd1, 15, "level_steady");
    if (last_push) n++;
    drive_beat(64'hA0 + n, 0, 0, 1);
    for (int i = 0; i < 10 && !last_push; i++) cycle();
    drain("drain_full");

    // store-and-forward: egress waits for the EOP push
    csr_wr(2'd0, 1);
    stream_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(64'hB0 + i, (i == 3) ? 3'd5 : 3'd0, i == 0, i == 3);
      #1 chk("sf_hold", stream_out_valid, 0);
      cycle();
    end
    idle_in();
    for (int i = 0; i < 4; i++) begin
      #1 chk("sf_burst", stream_out_valid, 1);
      cycle();
    end
    #1 chk("sf_done", stream_out_valid, 0);

    // oversize 20-beat packet in store-and-forward
    n = 0;
    drive_beat(64'hC0, 0, 1, 0);
    for (int i = 0; i < 80 && !(n == 20 && q.size() == 0); i++) begin
      cycle();
      if (last_push) n++;
      if (n >= 20) idle_in();
      else drive_beat(64'hC0 + n, (n == 19) ? 3'd2 : 3'd0, n == 0, n == 19);
    end
    chk("oversize_pushed", n, 20);
    chk("oversize_drained", q.size(), 0);
    csr_rd(2'd0, 3, "csr0_oversize");
    csr_wr(2'd0, 3);
    csr_rd(2'd0, 1, "csr0_w1c");

    // read and write collide: read served, write dropped
    csr_wr(2'd0, 0);
    stream_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(64'hD0 + i, 0, (i % 2) == 0, (i % 2) == 1);
      cycle();
    end
    idle_in();
    csr_read = 1; csr_write = 1; csr_address = 2'd2; csr_writedata = 1;
    cycle();
    csr_read = 0; csr_write = 0;
    chk("coll_pkt_count", csr_readdata, 2);
    csr_rd(2'd0, 0, "coll_sf_kept");
    drain("drain_coll");

    // asynchronous reset mid-packet at level 5
    stream_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive_beat(64'hE0 + i, 0, i == 0, 0);
      cycle();
    end
    csr_rd(2'd1, 5, "level_pre_reset");
    reset_n = 0;
    #1;
    chk("mid_rst_valid", stream_out_valid, 0);
    chk("mid_rst_ready", stream_in_ready, 0);
    chk("mid_rst_waitreq", csr_waitrequest, 1);
    @(negedge clk);
    idle_in();
    reset_n = 1;
    model_reset();
    csr_rd(2'd0, 0, "post_rst_csr0");
    csr_rd(2'd1, 0, "post_rst_level");
    csr_rd(2'd2, 0, "post_rst_pkt");
    csr_rd(2'd3, 0, "post_rst_hwm");

    // randomized traffic against the model
    pos = 0; len = $urandom_range(1, 24); bias = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 400 == 0) bias = $urandom_range(0, 1);
      if (last_push) begin
        pos++;
        if (pos == len) begin pos = 0; len = $urandom_range(1, 24); end
      end
      if (!stream_in_valid || last_push) begin
        if ($urandom_range(0, 3) != 0)
          drive_beat({$urandom, $urandom}, (pos == len - 1) ? 3'($urandom_range(0, 7)) : 3'd0,
                     pos == 0, pos == len - 1);
        else
          idle_in();
      end
      stream_out_ready = ($urandom_range(0, 9) < (bias ? 2 : 8));
      r = $urandom_range(0, 31);
      csr_read      = (r < 4);
      csr_write     = (r >= 3 && r < 6);
      csr_address   = 2'($urandom_range(0, 3));
      csr_writedata = 32'($urandom_range(0, 3));
      cycle();
    end
    csr_read = 0; csr_write = 0;
    csr_wr(2'd0, 0);
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_packet_fifo.md
Name: stream_packet_fifo

Overview:
Avalon-ST buffering stage placed directly downstream of the endian swapper. It absorbs backpressure bursts between the swapper's stream output and the egress sink. It supports two modes: cut-through (default) and store-and-forward, selected at runtime via CSR. An Avalon-MM CSR port exposes fill level, buffered packet count and a high watermark.

Parameters:
DATA_BYTES, 8, bytes per beat; data width is DATA_BYTES*8.
DEPTH, 16, FIFO entries; must be a power of 2 and at least 4.

Ports:
clk  input  1  clock
reset_n  input  1  async active-low reset
stream_in_data  input  DATA_BYTES*8  ingress beat data
stream_in_empty  input  $clog2(DATA_BYTES)  empty bytes on EOP beat
stream_in_valid  input  1  ingress valid
stream_in_startofpacket  input  1  ingress SOP
stream_in_endofpacket  input  1  ingress EOP
stream_in_ready  output  1  ingress ready (readyLatency 0)
stream_out_data  output  DATA_BYTES*8  egress data
stream_out_empty  output  $clog2(DATA_BYTES)  egress empty
stream_out_valid  output  1  egress valid
stream_out_startofpacket  output  1  egress SOP
stream_out_endofpacket  output  1  egress EOP
stream_out_ready  input  1  egress ready
csr_address  input  2  CSR word address
csr_read  input  1  CSR read strobe
csr_write  input  1  CSR write strobe
csr_writedata  input  32  CSR write data
csr_readdata  output  32  CSR read data
csr_readdatavalid  output  1  read data valid, fixed readLatency 1
csr_waitrequest  output  1  CSR stall

Behaviour:
- Reset is asynchronous, active-low on reset_n. Reset values: all pointers, level, pkt_count, hwm, mode and sticky = 0; csr_readdatavalid = 0; csr_readdata = 0.
- csr_waitrequest = !reset_n; it is never asserted otherwise.
- Storage: each entry holds {data, empty, sop, eop}. Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally. Level is a separate $clog2(DEPTH+1)-bit counter.
- stream_in_ready = reset_n & (level != DEPTH). It is combinational from registered state and does not depend on stream_in_valid.
- Push: occurs on stream_in_valid & stream_in_ready.
- Pop: occurs on stream_out_valid & stream_out_ready.
- Simultaneous push and pop leave level unchanged. The FIFO is allowed to be full with pop and no push.
- First-word-fall-through: stream_out_* present the entry at the read pointer combinationally.
- Latency: a beat pushed at edge N can be popped at edge N+1. There is no bypass when empty.
- Empty FIFO: stream_out_valid = 0.
- pkt_count counts beats with eop that have been pushed but not yet popped. It increments on push of an eop beat and decrements on pop of an eop beat; both in the same cycle leave it unchanged.
- Mode bit sf, CSR 0 bit 0:
  - sf = 0: stream_out_valid = (level != 0).
  - sf = 1: stream_out_valid = (level != 0) & (pkt_count != 0 | release).
- Oversize release (sf = 1 only):
  - When level == DEPTH and pkt_count == 0, set release and set sticky oversize (CSR 0 bit 1). This prevents deadlock.
  - release clears on pop of an eop beat and on reset.
- A mode change takes effect the cycle after the write. It is legal mid-packet.
- hwm: updates to max(hwm, next level) every cycle.
- CSR map:
  - 0: [R/W] bit0 sf; [R/W1C] bit1 oversize; bits 31-2 read 0.
  - 1: [RO] level, zero-extended.
  - 2: [RO] pkt_count, zero-extended.
  - 3: [RO] hwm; any write sets hwm to the current level.
- CSR read: csr_readdatavalid is 1 exactly one cycle after csr_read, and csr_readdata is registered. Unmapped fields read 0.
- csr_read and csr_write in the same cycle: the read is served and the write is ignored.
- W1C on oversize in the same cycle as a new set condition: the set wins.
- Stream protocol errors (missing SOP/EOP) are passed through unchecked. The FIFO is transparent to framing.

Test Plan:
- sf=0, ready=1, push 3-beat packet (data 0x1111..,0x2222..,0x3333.., empty=3 on EOP) -> same beats out 1 cycle after each push; level peaks at 1; CSR3 reads 1.
- sf=0, stream_out_ready=0, push 16 beats -> stream_in_ready drops after the 16th push; CSR1 reads 16. Set stream_out_ready=1 with stream_in_valid held -> push and pop each cycle; level stays at 15 or 16; order is preserved.
- Write CSR0=1, ready=1, push 4-beat packet -> stream_out_valid stays 0 until the EOP push, rises the next cycle, and all 4 beats stream out back-to-back.
- sf=1, push a 20-beat packet with DEPTH=16 -> at level 16 release asserts and output drains; packet is complete and in order; CSR0 reads 0x3. Write CSR0=0x3 -> reads 0x1.
- Assert reset_n=0 mid-packet with level=5 -> immediately stream_out_valid=0 and stream_in_ready=0; after release, all CSRs read 0.
- Issue csr_read on addr 2 with 2 complete packets buffered -> csr_readdatavalid=1 next cycle with csr_readdata=2. A simultaneous csr_write to addr 0 leaves sf unchanged.
